// File: rtl/bsg_circular_ptr_gen.sv
// bsg_circular_ptr_gen: circular pointer over slots_p slots with wrap phase, wrap pulse and load.
//   clk        in   clock, rising edge
//   reset_n_i  in   asynchronous active-low reset
//   add_i      in   increment for this cycle (0 holds)
//   load_v_i   in   load request, overrides add_i
//   load_ptr_i in   value loaded when load_v_i=1
//   o          out  registered pointer
//   n_o        out  combinational next pointer
//   phase_o    out  registered phase, toggles on every wrap, cleared by load
//   wrap_o     out  registered pulse, high the cycle after a wrapping update
//   error_o    out  sticky illegal-input flag, only live with BSG_CIRCULAR_PTR_GEN_CHECK_EN defined
module bsg_circular_ptr_gen #(
    parameter int slots_p   = 32,
    parameter int max_add_p = 7,
    localparam int ptr_width_lp = (slots_p < 2) ? 1 : $clog2(slots_p),
    localparam int add_width_lp = $clog2(max_add_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic [add_width_lp-1:0] add_i,
    input  logic                    load_v_i,
    input  logic [ptr_width_lp-1:0] load_ptr_i,
    output logic [ptr_width_lp-1:0] o,
    output logic [ptr_width_lp-1:0] n_o,
    output logic                    phase_o,
    output logic                    wrap_o,
    output logic                    error_o
);
    localparam int sum_width_lp = ptr_width_lp + 1;
    localparam logic [sum_width_lp-1:0] slots_lp = sum_width_lp'(slots_p);
    logic [ptr_width_lp-1:0] r_ptr;
    logic                    r_phase;
    logic                    r_wrap;
    logic [sum_width_lp-1:0] w_sum;
    logic                    w_wrap;
    // one extra bit so o + add_i never truncates before the wrap compare
    assign w_sum  = {1'b0, r_ptr} + sum_width_lp'(add_i);
    assign w_wrap = ~load_v_i & (w_sum >= slots_lp);
    always_comb begin
        n_o = load_v_i ? load_ptr_i
            : w_wrap   ? ptr_width_lp'(w_sum - slots_lp)
            :            ptr_width_lp'(w_sum);
    end
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr   <= '0;
            r_phase <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_ptr   <= n_o;
            r_phase <= load_v_i ? 1'b0 : (r_phase ^ w_wrap);
            r_wrap  <= w_wrap;
        end
    end
    assign o       = r_ptr;
    assign phase_o = r_phase;
    assign wrap_o  = r_wrap;
`ifdef BSG_CIRCULAR_PTR_GEN_CHECK_EN
    localparam logic [add_width_lp-1:0] max_add_lp = add_width_lp'(max_add_p);
    logic r_error;
    logic w_bad;
    assign w_bad = load_v_i ? ({1'b0, load_ptr_i} >= slots_lp) : (add_i > max_add_lp);
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) r_error <= 1'b0;
        else            r_error <= r_error | w_bad;
    end
    assign error_o = r_error;
`else
    assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_bsg_circular_ptr_gen.sv
// tb_bsg_circular_ptr_gen: directed checks on a 5-slot pointer plus a modulo-32 run on a 32-slot pointer.
module tb_bsg_circular_ptr_gen;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] add_a = '0;
    logic       load_a = 1'b0;
    logic [2:0] lptr_a = '0;
    logic [2:0] o_a, n_a;
    logic       ph_a, wr_a, er_a;
    logic [2:0] add_b = '0;
    logic [4:0] o_b, n_b;
    logic       ph_b, wr_b, er_b;
    int         vecs = 0;
    int         errs = 0;
    int         m;
    logic       exp_err;

    always #5 clk = ~clk;

    bsg_circular_ptr_gen #(.slots_p(5), .max_add_p(5)) dut_a (
        .clk(clk), .reset_n_i(reset_n), .add_i(add_a), .load_v_i(load_a),
        .load_ptr_i(lptr_a), .o(o_a), .n_o(n_a), .phase_o(ph_a),
        .wrap_o(wr_a), .error_o(er_a)
    );

    bsg_circular_ptr_gen #(.slots_p(32), .max_add_p(7)) dut_b (
        .clk(clk), .reset_n_i(reset_n), .add_i(add_b), .load_v_i(1'b0),
        .load_ptr_i(5'd0), .o(o_b), .n_o(n_b), .phase_o(ph_b),
        .wrap_o(wr_b), .error_o(er_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int eo, input int eph, input int ewr);
        check({tag, " o"}, int'(o_a), eo);
        check({tag, " phase"}, int'(ph_a), eph);
        check({tag, " wrap"}, int'(wr_a), ewr);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef BSG_CIRCULAR_PTR_GEN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (2) step();
        chk_a("in_reset", 0, 0, 0);
        check("in_reset err", int'(er_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("hold", 0, 0, 0);
        end
        add_a = 3'd3;
        step();
        chk_a("add3 a", 3, 0, 0);
        step();
        chk_a("add3 b", 1, 1, 1);
        step();
        chk_a("add3 c", 4, 1, 0);
        check("n_o wrap", int'(n_a), 2);
        load_a = 1'b1;
        lptr_a = 3'd1;
        #1;
        check("n_o load", int'(n_a), 1);
        step();
        chk_a("load", 1, 0, 0);
        load_a = 1'b0;
        add_a = 3'd1;
        step();
        chk_a("to2", 2, 0, 0);
        add_a = 3'd5;
        step();
        chk_a("lap a", 2, 1, 1);
        step();
        chk_a("lap b", 2, 0, 1);
        add_a = 3'd0;
        step();
        chk_a("lap end", 2, 0, 0);
        add_a = 3'd5;
        step();
        chk_a("pre rst", 2, 1, 1);
        add_a = 3'd3;
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("async rst", 0, 0, 0);
        step();
        chk_a("rst held", 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        add_a = 3'd0;
        step();
        chk_a("post rst", 0, 0, 0);
        add_a = 3'd6;
        step();
        check("err set", int'(er_a), int'(exp_err));
        add_a = 3'd0;
        step();
        check("err held", int'(er_a), int'(exp_err));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("err cleared", int'(er_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        m = 0;
        for (int i = 0; i < 300; i++) begin
            add_b = 3'($urandom_range(0, 7));
            #1;
            check("pow2 n_o", int'(n_b), (m + int'(add_b)) % 32);
            step();
            check("pow2 wrap", int'(wr_b), int'(m + int'(add_b) >= 32));
            m = (m + int'(add_b)) % 32;
            check("pow2 o", int'(o_b), m);
            @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
